// File: rtl/motion_sequencer_pkg.sv
// Shared codes for the motion sequencer: motor drive codes, command opcodes,
// FSM state encodings and heading arithmetic helpers.
package motion_sequencer_pkg;

    localparam logic [2:0] MOTOR_FORWARD = 3'd0;
    localparam logic [2:0] MOTOR_BACK    = 3'd1;
    localparam logic [2:0] MOTOR_LEFT    = 3'd2;
    localparam logic [2:0] MOTOR_RIGHT   = 3'd3;
    localparam logic [2:0] MOTOR_STOP    = 3'd4;

    localparam logic [1:0] OP_FWD  = 2'd0;
    localparam logic [1:0] OP_BACK = 2'd1;
    localparam logic [1:0] OP_TURN = 2'd2;
    localparam logic [1:0] OP_HOLD = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DRIVE  = 3'd2;
    localparam logic [2:0] ST_TURN   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_SETTLE = 3'd5;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] arg;
    } cmd_t;

    // Odometer heading runs 0..720; fold it back into 0..359.
    function automatic logic [8:0] normHeading(input logic [11:0] angle);
        if (angle >= 12'd720)
            return 9'(angle - 12'd720);
        else if (angle >= 12'd360)
            return 9'(angle - 12'd360);
        else
            return 9'(angle);
    endfunction

    function automatic logic [15:0] wrapTarget(input logic [15:0] tgt);
        return (tgt >= 16'd360) ? tgt - 16'd360 : tgt;
    endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Command handshake between a command source (master) and the sequencer (slave).
interface motion_sequencer_if;
    import motion_sequencer_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/motion_sequencer_cmd_fifo.sv
// Synchronous command FIFO with flush; a push that coincides with a flush survives.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full   = (count_q == FULL_COUNT);
    assign empty  = (count_q == '0);
    assign doPush = push & (~full | pop);
    assign doPop  = pop & ~empty;
    assign rdata  = mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush)
            mem_q[wrPtr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            rdPtr_q <= wrPtr_q;
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
                count_q <= {{AW{1'b0}}, 1'b1};
            end else begin
                count_q <= '0;
            end
        end else begin
            if (doPush)
                wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)
                rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/motion_sequencer.sv
// Command-level motion controller: queues moves, drives the motor code and closes
// each move on odometer feedback, with settle time, watchdog and abort.
module motion_sequencer
    import motion_sequencer_pkg::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int SETTLE_US  = 20000,
    parameter int TIMEOUT_CM = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clock_1MHz,
    motion_sequencer_if.slave cmd,
    input  logic              cm_tick,
    input  logic [11:0]       total_angle,
    input  logic              abort,
    output logic [2:0]        motor_out,
    output logic              busy,
    output logic              move_done,
    output logic              err_timeout,
    output logic [15:0]       moves_done
);
    localparam logic [25:0] SETTLE_LAST = 26'(SETTLE_US - 1);
    localparam logic [15:0] WD_LIMIT    = 16'(TIMEOUT_CM);

    logic [2:0]  sync_q;
    logic [2:0]  state_q, state_d;
    logic [2:0]  motor_q, motor_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] target_q, target_d;
    logic [25:0] tickCnt_q, tickCnt_d;
    logic [15:0] moves_q, moves_d;
    logic        moveDone_q, moveDone_d;
    logic        err_q, err_d;

    logic        tick, push, pop, flush, cmdReady;
    logic        fifoFull, fifoEmpty, finishMove, timeoutHit, wdExpired;
    logic [17:0] fifoData;
    cmd_t        head;
    logic [8:0]  heading;
    logic [15:0] fetchTarget;
    logic [9:0]  diffRaw, diffMod;
    logic [25:0] tickInc;

    cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(18)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({cmd.cmd_op, cmd.cmd_arg}),
        .rdata (fifoData),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign head          = cmd_t'(fifoData);
    assign tick          = sync_q[1] & ~sync_q[2];
    assign pop           = (state_q == ST_FETCH) & ~abort;
    assign cmdReady      = ~abort & (~fifoFull | pop);
    assign cmd.cmd_ready = cmdReady;
    assign push          = cmd.cmd_valid & cmdReady;

    // Turn direction is chosen once at fetch from the shortest signed distance.
    assign heading     = normHeading(total_angle);
    assign fetchTarget = wrapTarget(head.arg);
    assign diffRaw     = 10'(fetchTarget) + 10'd360 - {1'b0, heading};
    assign diffMod     = (diffRaw >= 10'd360) ? diffRaw - 10'd360 : diffRaw;
    assign tickInc     = tickCnt_q + 1'b1;
    assign wdExpired   = (tickInc[25:10] == WD_LIMIT);

    always_comb begin
        state_d     = state_q;
        motor_d     = motor_q;
        remaining_d = remaining_q;
        target_d    = target_q;
        tickCnt_d   = tickCnt_q;
        err_d       = err_q;
        moves_d     = moves_q;
        moveDone_d  = 1'b0;
        flush       = 1'b0;
        finishMove  = 1'b0;
        timeoutHit  = 1'b0;
        if (push)
            err_d = 1'b0;
        if (abort && (state_q != ST_IDLE || !fifoEmpty)) begin
            state_d   = ST_SETTLE;
            motor_d   = MOTOR_STOP;
            tickCnt_d = '0;
            flush     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (!fifoEmpty) state_d = ST_FETCH;
                ST_FETCH: begin
                    tickCnt_d   = '0;
                    remaining_d = head.arg;
                    target_d    = fetchTarget;
                    case (head.op)
                        OP_FWD, OP_BACK: begin
                            if (head.arg == 16'd0) finishMove = 1'b1;
                            else begin
                                state_d = ST_DRIVE;
                                motor_d = (head.op == OP_FWD) ? MOTOR_FORWARD : MOTOR_BACK;
                            end
                        end
                        OP_TURN: begin
                            if (diffMod == 10'd0) finishMove = 1'b1;
                            else begin
                                state_d = ST_TURN;
                                motor_d = (diffMod <= 10'd180) ? MOTOR_LEFT : MOTOR_RIGHT;
                            end
                        end
                        default: begin
                            if (head.arg == 16'd0) finishMove = 1'b1;
                            else begin
                                state_d = ST_HOLD;
                                motor_d = MOTOR_STOP;
                            end
                        end
                    endcase
                end
                ST_DRIVE: begin
                    if (cm_tick && remaining_q == 16'd1) finishMove = 1'b1;
                    else begin
                        if (cm_tick) remaining_d = remaining_q - 1'b1;
                        if (tick) begin
                            tickCnt_d  = tickInc;
                            timeoutHit = wdExpired;
                        end
                    end
                end
                ST_TURN: begin
                    if ({7'd0, heading} == target_q) finishMove = 1'b1;
                    else if (tick) begin
                        tickCnt_d  = tickInc;
                        timeoutHit = wdExpired;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (tickCnt_q == 26'd999) begin
                            tickCnt_d = '0;
                            if (remaining_q == 16'd1) finishMove = 1'b1;
                            else remaining_d = remaining_q - 1'b1;
                        end else begin
                            tickCnt_d = tickInc;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        if (tickCnt_q == SETTLE_LAST) state_d = ST_IDLE;
                        else tickCnt_d = tickInc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (finishMove) begin
                state_d    = ST_SETTLE;
                motor_d    = MOTOR_STOP;
                tickCnt_d  = '0;
                moveDone_d = 1'b1;
                moves_d    = moves_q + 1'b1;
            end
            if (timeoutHit) begin
                state_d   = ST_SETTLE;
                motor_d   = MOTOR_STOP;
                tickCnt_d = '0;
                err_d     = 1'b1;
                flush     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            motor_q     <= MOTOR_STOP;
            remaining_q <= '0;
            target_q    <= '0;
            tickCnt_q   <= '0;
            moves_q     <= '0;
            moveDone_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], clock_1MHz};
            state_q     <= state_d;
            motor_q     <= motor_d;
            remaining_q <= remaining_d;
            target_q    <= target_d;
            tickCnt_q   <= tickCnt_d;
            moves_q     <= moves_d;
            moveDone_q  <= moveDone_d;
            err_q       <= err_d;
        end
    end

    assign motor_out   = motor_q;
    assign busy        = (state_q != ST_IDLE) | ~fifoEmpty;
    assign move_done   = moveDone_q;
    assign err_timeout = err_q;
    assign moves_done  = moves_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Self-checking bench for motion_sequencer: vector table for move types plus
// hand-written sequences for settle, FIFO-full, watchdog, abort and reset.
module tb_motion_sequencer;

    localparam logic [2:0] M_FWD = 3'd0, M_BACK = 3'd1, M_LEFT = 3'd2, M_RIGHT = 3'd3, M_STOP = 3'd4;
    localparam logic [1:0] C_FWD = 2'd0, C_BACK = 2'd1, C_TURN = 2'd2, C_HOLD = 2'd3;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        logic [11:0] angle0;
        logic [11:0] angleEnd;
        logic [2:0]  expMotor;
    } vec_t;

    logic        clk = 1'b0;
    logic        clock_1MHz = 1'b0;
    logic        reset = 1'b1;
    logic        cm_tick = 1'b0;
    logic [11:0] total_angle = 12'd0;
    logic        abort = 1'b0;
    logic [2:0]  motor_out;
    logic        busy, move_done, err_timeout;
    logic [15:0] moves_done;

    int          checks = 0;
    int          fails = 0;
    logic [15:0] modelMoves = 16'd0;
    logic [15:0] expQ[$];
    vec_t        vecs[10];

    motion_sequencer_if cmdBus ();

    motion_sequencer #(.CMD_DEPTH(4), .SETTLE_US(20), .TIMEOUT_CM(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .clock_1MHz  (clock_1MHz),
        .cmd         (cmdBus.slave),
        .cm_tick     (cm_tick),
        .total_angle (total_angle),
        .abort       (abort),
        .motor_out   (motor_out),
        .busy        (busy),
        .move_done   (move_done),
        .err_timeout (err_timeout),
        .moves_done  (moves_done)
    );

    always #5 clk = ~clk;
    always #20 clock_1MHz = ~clock_1MHz;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] arg, input bit expectDone);
        int n = 0;
        @(negedge clk);
        while (!cmdBus.cmd_ready && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (!cmdBus.cmd_ready) checkOutput("cmd_ready wait", 0, 1);
        cmdBus.cmd_valid = 1'b1;
        cmdBus.cmd_op    = op;
        cmdBus.cmd_arg   = arg;
        @(posedge clk);
        #1 cmdBus.cmd_valid = 1'b0;
        if (expectDone) begin
            modelMoves++;
            expQ.push_back(modelMoves);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle reached", int'(busy), 0);
    endtask

    task automatic waitMotor(input logic [2:0] code, input int budget);
        int n = 0;
        while (motor_out != code && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (motor_out != code) checkOutput("motor wait", int'(motor_out), int'(code));
    endtask

    task automatic pulseTick();
        @(negedge clk) cm_tick = 1'b1;
        @(negedge clk) cm_tick = 1'b0;
    endtask

    // Scoreboard: every completed move must match the next expected count.
    always @(negedge clk) begin
        if (!reset && move_done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected move_done", 1, 0);
            end else begin
                checkOutput("moves_done at move_done", int'(moves_done), int'(expQ.pop_front()));
                checkOutput("motor stop at move_done", int'(motor_out), int'(M_STOP));
            end
        end
    end

    initial begin
        int n;
        int step;
        vecs[0] = '{C_TURN, 16'd90,  12'd0,   12'd90,  M_LEFT};
        vecs[1] = '{C_TURN, 16'd0,   12'd370, 12'd360, M_RIGHT};
        vecs[2] = '{C_TURN, 16'd180, 12'd0,   12'd180, M_LEFT};
        vecs[3] = '{C_TURN, 16'd190, 12'd720, 12'd550, M_RIGHT};
        vecs[4] = '{C_TURN, 16'd400, 12'd360, 12'd400, M_LEFT};
        vecs[5] = '{C_FWD,  16'd3,   12'd0,   12'd0,   M_FWD};
        vecs[6] = '{C_BACK, 16'd2,   12'd0,   12'd0,   M_BACK};
        vecs[7] = '{C_FWD,  16'd0,   12'd0,   12'd0,   M_STOP};
        vecs[8] = '{C_TURN, 16'd50,  12'd410, 12'd410, M_STOP};
        vecs[9] = '{C_HOLD, 16'd1,   12'd0,   12'd0,   M_STOP};

        cmdBus.cmd_valid = 1'b0;
        cmdBus.cmd_op    = 2'd0;
        cmdBus.cmd_arg   = 16'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset motor_out", int'(motor_out), int'(M_STOP));
        checkOutput("reset cmd_ready", int'(cmdBus.cmd_ready), 1);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset move_done", int'(move_done), 0);
        checkOutput("reset err_timeout", int'(err_timeout), 0);
        checkOutput("reset moves_done", int'(moves_done), 0);

        for (int i = 0; i < 10; i++) begin
            total_angle = vecs[i].angle0;
            applyStimulus(vecs[i].op, vecs[i].arg, 1'b1);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d motor", i), int'(motor_out), int'(vecs[i].expMotor));
            if ((vecs[i].op == C_FWD || vecs[i].op == C_BACK) && vecs[i].arg != 16'd0) begin
                for (int k = 0; k < int'(vecs[i].arg); k++) begin
                    if (k == int'(vecs[i].arg) - 1)
                        checkOutput($sformatf("vec%0d motor before last tick", i), int'(motor_out), int'(vecs[i].expMotor));
                    pulseTick();
                    repeat (2) @(negedge clk);
                end
            end else if (vecs[i].op == C_TURN && vecs[i].angle0 != vecs[i].angleEnd) begin
                step = (vecs[i].angleEnd > vecs[i].angle0) ? 10 : -10;
                while (total_angle != vecs[i].angleEnd) begin
                    if (int'(total_angle) + step == int'(vecs[i].angleEnd))
                        checkOutput($sformatf("vec%0d motor before target", i), int'(motor_out), int'(vecs[i].expMotor));
                    total_angle = 12'(int'(total_angle) + step);
                    repeat (2) @(negedge clk);
                end
            end
            waitIdle(6000);
        end
        checkOutput("moves after table", int'(moves_done), 10);

        // FWD 5 with widely spaced odometer ticks, then the settle window
        total_angle = 12'd0;
        applyStimulus(C_FWD, 16'd5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            repeat (800) @(negedge clk);
            pulseTick();
        end
        repeat (800) @(negedge clk);
        checkOutput("fwd5 motor before 5th tick", int'(motor_out), int'(M_FWD));
        pulseTick();
        repeat (70) @(negedge clk);
        checkOutput("settle busy", int'(busy), 1);
        checkOutput("settle motor", int'(motor_out), int'(M_STOP));
        repeat (15) @(negedge clk);
        checkOutput("settle ended", int'(busy), 0);
        checkOutput("moves after fwd5", int'(moves_done), int'(modelMoves));

        // FIFO fill behind a running hold; fifth command must be refused
        applyStimulus(C_HOLD, 16'd1, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(C_FWD, 16'd1, 1'b1);
        applyStimulus(C_BACK, 16'd1, 1'b1);
        applyStimulus(C_FWD, 16'd1, 1'b1);
        applyStimulus(C_BACK, 16'd1, 1'b1);
        @(negedge clk);
        checkOutput("full cmd_ready", int'(cmdBus.cmd_ready), 0);
        cmdBus.cmd_valid = 1'b1;
        cmdBus.cmd_op    = C_TURN;
        cmdBus.cmd_arg   = 16'd90;
        @(posedge clk);
        #1 cmdBus.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (motor_out == M_STOP && n < 6000) begin
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("queued move %0d motor", k), int'(motor_out), (k % 2 == 0) ? int'(M_FWD) : int'(M_BACK));
            pulseTick();
        end
        waitIdle(500);
        checkOutput("moves after fifo fill", int'(moves_done), int'(modelMoves));

        // Watchdog: no odometer ticks, second command must be flushed
        applyStimulus(C_FWD, 16'd10, 1'b0);
        applyStimulus(C_FWD, 16'd3, 1'b0);
        n = 0;
        while (!err_timeout && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout raised", int'(err_timeout), 1);
        checkOutput("timeout latency in window", int'(n >= 16370 && n <= 16400), 1);
        checkOutput("timeout motor", int'(motor_out), int'(M_STOP));
        waitIdle(500);
        checkOutput("timeout sticky", int'(err_timeout), 1);
        checkOutput("moves after timeout", int'(moves_done), int'(modelMoves));
        applyStimulus(C_FWD, 16'd0, 1'b1);
        @(negedge clk);
        checkOutput("err cleared by accept", int'(err_timeout), 0);
        waitIdle(500);

        // Abort mid-drive with two commands queued
        applyStimulus(C_FWD, 16'd5, 1'b0);
        applyStimulus(C_FWD, 16'd2, 1'b0);
        applyStimulus(C_BACK, 16'd2, 1'b0);
        waitMotor(M_FWD, 20);
        @(negedge clk) abort = 1'b1;
        @(negedge clk);
        checkOutput("abort motor", int'(motor_out), int'(M_STOP));
        checkOutput("abort cmd_ready", int'(cmdBus.cmd_ready), 0);
        abort = 1'b0;
        waitIdle(500);
        checkOutput("moves after abort", int'(moves_done), int'(modelMoves));
        @(negedge clk) abort = 1'b1;
        @(negedge clk);
        checkOutput("idle abort ready", int'(cmdBus.cmd_ready), 0);
        checkOutput("idle abort busy", int'(busy), 0);
        abort = 1'b0;

        // Reset in the middle of a turn
        total_angle = 12'd0;
        applyStimulus(C_TURN, 16'd90, 1'b0);
        waitMotor(M_LEFT, 20);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        checkOutput("mid-turn reset motor", int'(motor_out), int'(M_STOP));
        checkOutput("mid-turn reset busy", int'(busy), 0);
        checkOutput("mid-turn reset moves", int'(moves_done), 0);
        checkOutput("mid-turn reset ready", int'(cmdBus.cmd_ready), 1);
        reset = 1'b0;
        modelMoves = 16'd0;
        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
